writeback_arbiter: RTL
======================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = CSR).
REQ-002 Port clk  input  1  single clock; all state updates on posedge.
REQ-003 Port rst  input  1  reset: asynchronous, active-high.
REQ-004 Port req_valid  input  NUM_REQ  per-requester write request.
REQ-005 Port req_ready  output  NUM_REQ  per-requester grant; a transfer occurs when valid && ready.
REQ-006 Port req_rd_index  input  NUM_REQ x 5  destination register per requester.
REQ-007 Port req_data  input  NUM_REQ x 32  write data per requester (Types::uint32_t).
REQ-008 Port issue_valid  input  1  an instruction with a destination register was issued this cycle.
REQ-009 Port issue_rd_index  input  5  destination of the issued instruction.
REQ-010 Port flush  input  1  synchronous clear of all pending marks.
REQ-011 Port rs1_index, rs2_index  input  5 each  source registers to check.
REQ-012 Port rs1_busy, rs2_busy  output  1 each  source has an outstanding write.
REQ-013 Port rd_index  output  5  register-file write index.
REQ-014 Port rd_in  output  32  register-file write data.
REQ-015 Port rd_w  output  1  register-file write enable.
REQ-016 Port pending  output  32  scoreboard vector; bit i = register i awaits writeback.

Function
REQ-017 At most one req_ready bit SHALL be high per cycle, and only for a requester with req_valid high.
REQ-018 req_ready SHALL be combinational from req_valid and the round-robin pointer; there is no other backpressure.
REQ-019 Arbitration SHALL be round-robin: the search starts at (last_grant + 1) mod NUM_REQ; last_grant updates on every grant and holds otherwise.
REQ-020 A grant in cycle N SHALL register rd_index/rd_in on posedge ending N; rd_w SHALL be high for exactly cycle N+1 (one-cycle latency).
REQ-021 Cycles with no grant SHALL drive rd_w = 0; rd_index and rd_in SHALL hold their last values.
REQ-022 A granted request with req_rd_index = 0 SHALL complete the handshake but SHALL drive rd_w = 0.
REQ-023 Back-to-back grants SHALL produce rd_w high on consecutive cycles, with no bubble.
REQ-024 issue_valid with a nonzero issue_rd_index SHALL set pending[issue_rd_index] on the next posedge; index 0 SHALL never be set.
REQ-025 A grant SHALL clear pending[req_rd_index] on the same posedge that loads the output register.
REQ-026 A set and a clear of the same index in one cycle: set SHALL win.
REQ-027 flush SHALL clear all pending bits next posedge and SHALL take priority over same-cycle issue; in-flight grants still write.
REQ-028 rsX_busy SHALL equal pending[rsX_index] (registered state, no bypass); index 0 SHALL always read 0.

Reset
REQ-029 While rst is high: rd_w = 0, rd_index = 0, rd_in = 0, pending = 0, last_grant = NUM_REQ-1 (requester 0 first), req_ready = 0.
REQ-030 Reset asserted mid-transfer SHALL drop rd_w immediately; the lost write is not replayed.

Structure
REQ-031 Types SHALL hold the reg_index_t (5-bit) typedef and the NUM_WB_REQ constant; the module SHALL use Types::uint32_t for data.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (parameter N; inputs req and pointer; outputs one-hot grant and grant index).

Verification
REQ-033 Reset, then ALU writes x5 = 0xDEADBEEF -> req_ready[0] same cycle; next cycle rd_w=1, rd_index=5, rd_in=0xDEADBEEF; then rd_w=0.
REQ-034 All three valid for 6 cycles, destinations x1/x2/x3 -> grant order 0,1,2,0,1,2 and rd_w high for 6 consecutive cycles.
REQ-035 Issue x7; two cycles later LSU writes x7 -> pending[7] and rs1_busy (rs1_index=7) high until the grant edge, then 0.
REQ-036 Same cycle: issue x9 and CSR grant writing x9 -> pending[9] stays 1; issue x0 -> pending[0] stays 0; write x0 -> rd_w stays 0.
REQ-037 pending = {x4,x8}, flush with issue x10 -> pending = 0 next cycle.
REQ-038 rst pulse between grant and the write cycle -> rd_w stays 0, pending = 0, next simultaneous request from all three granted to requester 0.

Source files
------------

// File: rtl/Types.sv
// Shared scalar types for the writeback path.
package Types;
   typedef logic [31:0] uint32_t;
   typedef logic [4:0]  reg_index_t;
   localparam int unsigned NUM_WB_REQ = 3;
endpackage

// File: rtl/writeback_arbiter_pkg.sv
// Local types and helpers for the writeback arbiter.
package writeback_arbiter_pkg;
   typedef struct packed {
      logic             w;
      Types::reg_index_t idx;
      Types::uint32_t    data;
   } wb_write_t;

   // Register 0 is hardwired, so it never maps to a scoreboard bit.
   function automatic logic [31:0] reg_onehot(input Types::reg_index_t idx);
      return (idx == '0) ? '0 : (32'd1 << idx);
   endfunction
endpackage

// File: rtl/writeback_arbiter_if.sv
// Requester-side writeback handshake bundle.
interface writeback_arbiter_if #(
   parameter int unsigned NUM_REQ = Types::NUM_WB_REQ
);
   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ-1:0]              req_ready;
   Types::reg_index_t [NUM_REQ-1:0] req_rd_index;
   Types::uint32_t    [NUM_REQ-1:0] req_data;

   modport master (output req_valid, req_rd_index, req_data, input req_ready);
   modport slave  (input req_valid, req_rd_index, req_data, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector; search begins one past the pointer.
module rr_arbiter #(
   parameter int unsigned N = 3,
   parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] pointer,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx
);
   logic [W-1:0] jj;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      jj        = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         jj = W'((32'(pointer) + k) % N);
         if ((grant == '0) && req[jj]) begin
            grant[jj] = 1'b1;
            grant_idx = jj;
         end
      end
   end
endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter with registered register-file port and
// a pending-write scoreboard for source-operand hazard checks.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = Types::NUM_WB_REQ
) (
   input  logic                 clk,
   input  logic                 rst,
   writeback_arbiter_if.slave   wb,
   input  logic                 issue_valid,
   input  Types::reg_index_t    issue_rd_index,
   input  logic                 flush,
   input  Types::reg_index_t    rs1_index,
   input  Types::reg_index_t    rs2_index,
   output logic                 rs1_busy,
   output logic                 rs2_busy,
   output Types::reg_index_t    rd_index,
   output Types::uint32_t       rd_in,
   output logic                 rd_w,
   output logic [31:0]          pending
);
   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0]      last_grant_q, last_grant_d;
   logic [NUM_REQ-1:0] grant;
   logic [PW-1:0]      grant_idx;
   logic               grant_any;
   Types::reg_index_t  win_idx;
   Types::uint32_t     win_data;
   wb_write_t          out_q, out_d;
   logic [31:0]        pending_q, pending_d;

   rr_arbiter #(.N(NUM_REQ), .W(PW)) u_rr (
      .req       (wb.req_valid),
      .pointer   (last_grant_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign wb.req_ready = rst ? '0 : grant;
   assign grant_any    = |grant;
   assign win_idx      = wb.req_rd_index[grant_idx];
   assign win_data     = wb.req_data[grant_idx];

   always_comb begin
      last_grant_d = grant_any ? grant_idx : last_grant_q;
      out_d        = out_q;
      out_d.w      = 1'b0;
      if (grant_any) begin
         out_d = '{w: (win_idx != '0), idx: win_idx, data: win_data};
      end
      // Clear first so a same-cycle issue re-marks the register; flush beats both.
      pending_d = pending_q;
      if (grant_any)   pending_d = pending_d & ~reg_onehot(win_idx);
      if (issue_valid) pending_d = pending_d | reg_onehot(issue_rd_index);
      if (flush)       pending_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= PW'(NUM_REQ - 1);
         out_q        <= '0;
         pending_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         out_q        <= out_d;
         pending_q    <= pending_d;
      end
   end

   assign rd_w     = out_q.w;
   assign rd_index = out_q.idx;
   assign rd_in    = out_q.data;
   assign pending  = pending_q;
   assign rs1_busy = (rs1_index != '0) && pending_q[rs1_index];
   assign rs2_busy = (rs2_index != '0) && pending_q[rs2_index];
endmodule
